// File: rtl/iq_deinterleave.sv
// iq_deinterleave
// Converts the interleaved byte stream from the RF capture FIFO (I low, I high,
// Q low, Q high per complex sample) into separate signed I and Q samples and
// writes them into the I/Q FIFO pair together, in one cycle.
//
// Optional feature macro: IQ_QUANTIZE_EN
//   defined   : outputs are sext(sample) << BITS (fixed-point quantize step)
//   undefined : outputs are sext(sample), BITS has no effect
//
// Ports:
//   clock        single clock for all logic
//   reset        synchronous, active-high reset
//   in_rd_en     pop one byte from the capture FIFO
//   in_empty     capture FIFO empty
//   din          capture FIFO head byte (first-word-fall-through)
//   I_out_wr_en  push I_dout into the I FIFO
//   Q_out_wr_en  push Q_dout into the Q FIFO (always equal to I_out_wr_en)
//   I_out_full   I FIFO full
//   Q_out_full   Q FIFO full
//   I_dout       signed I sample, DATA_WIDTH bits
//   Q_dout       signed Q sample, DATA_WIDTH bits
//   sample_count complex samples written since reset (wraps at 2^32)
//
// State   | meaning
// --------+-----------------------------------------------
// S_ILO   | waiting for / reading the I low byte
// S_IHI   | reading the I high byte
// S_QLO   | reading the Q low byte
// S_QHI   | reading the Q high byte; outputs load on exit
// S_WRITE | holding I/Q until both output FIFOs have room
module iq_deinterleave #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [7:0]            din,
  output logic                  I_out_wr_en,
  output logic                  Q_out_wr_en,
  input  logic                  I_out_full,
  input  logic                  Q_out_full,
  output logic [DATA_WIDTH-1:0] I_dout,
  output logic [DATA_WIDTH-1:0] Q_dout,
  output logic [31:0]           sample_count
);

`ifdef IQ_QUANTIZE_EN
  localparam int SHIFT = BITS;
`else
  // Raw pass-through: no shift.
  localparam int SHIFT = 0 * BITS;
`endif

  typedef enum logic [2:0] {
    S_ILO,
    S_IHI,
    S_QLO,
    S_QHI,
    S_WRITE
  } state_t;

  state_t state, state_next;

  logic [7:0]            ilo, ihi, qlo;
  logic signed [15:0]    i16, q16;
  logic [DATA_WIDTH-1:0] i_ext, q_ext;
  logic                  wr_en;

  // Q high byte is taken straight from din on the S_QHI exit, so it never
  // needs its own register.
  assign i16   = {ihi, ilo};
  assign q16   = {din, qlo};
  assign i_ext = DATA_WIDTH'(i16);
  assign q_ext = DATA_WIDTH'(q16);

  assign I_out_wr_en = wr_en;
  assign Q_out_wr_en = wr_en;

  always_comb begin
    state_next = state;
    in_rd_en   = 1'b0;
    wr_en      = 1'b0;
    // Enables are gated by reset so nothing moves during the reset cycle.
    if (!reset) begin
      case (state)
        S_ILO, S_IHI, S_QLO, S_QHI: begin
          in_rd_en = !in_empty;
          if (!in_empty) begin
            case (state)
              S_ILO:   state_next = S_IHI;
              S_IHI:   state_next = S_QLO;
              S_QLO:   state_next = S_QHI;
              default: state_next = S_WRITE;
            endcase
          end
        end
        S_WRITE: begin
          wr_en = !I_out_full && !Q_out_full;
          if (wr_en) state_next = S_ILO;
        end
        default: state_next = S_ILO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_ILO;
      ilo          <= '0;
      ihi          <= '0;
      qlo          <= '0;
      I_dout       <= '0;
      Q_dout       <= '0;
      sample_count <= '0;
    end else begin
      state <= state_next;
      if (in_rd_en) begin
        case (state)
          S_ILO: ilo <= din;
          S_IHI: ihi <= din;
          S_QLO: qlo <= din;
          S_QHI: begin
            I_dout <= i_ext << SHIFT;
            Q_dout <= q_ext << SHIFT;
          end
          default: ;
        endcase
      end
      if (wr_en) sample_count <= sample_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_iq_deinterleave.sv
module tb_iq_deinterleave;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_rd_en;
  logic        in_empty;
  logic [7:0]  din;
  logic        I_out_wr_en, Q_out_wr_en;
  logic        I_out_full, Q_out_full;
  logic [31:0] I_dout, Q_dout;
  logic [31:0] sample_count;

  int checks = 0;
  int errors = 0;

  logic [7:0]  bq[$];
  logic [31:0] exp_i[$], exp_q[$];

  logic        o_rd, o_wi, o_wq, o_e;
  logic [31:0] o_i, o_q;

  iq_deinterleave #(.DATA_WIDTH(32), .BITS(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_rd_en     (in_rd_en),
    .in_empty     (in_empty),
    .din          (din),
    .I_out_wr_en  (I_out_wr_en),
    .Q_out_wr_en  (Q_out_wr_en),
    .I_out_full   (I_out_full),
    .Q_out_full   (Q_out_full),
    .I_dout       (I_dout),
    .Q_dout       (Q_dout),
    .sample_count (sample_count)
  );

  always #5 clock = ~clock;

  // Reference: signed 16-bit value from two bytes, optionally scaled by 2^10.
  function automatic logic [31:0] model(input logic [7:0] lo, input logic [7:0] hi);
    int v;
    v = int'(hi) * 256 + int'(lo);
    if (v >= 32768) v = v - 65536;
`ifdef IQ_QUANTIZE_EN
    v = v * 1024;
`endif
    return 32'(v);
  endfunction

  task automatic push_sample(input logic [7:0] b0, b1, b2, b3);
    bq.push_back(b0); bq.push_back(b1); bq.push_back(b2); bq.push_back(b3);
    exp_i.push_back(model(b0, b1));
    exp_q.push_back(model(b2, b3));
  endtask

  // One clock of the capture FIFO / output FIFO environment. Observed outputs
  // are left in o_*; between steps the environment is idle (empty, full).
  task automatic step(input logic e, input logic fi, input logic fq);
    @(negedge clock);
    in_empty   = e || (bq.size() == 0);
    din        = (bq.size() != 0) ? bq[0] : 8'($urandom);
    I_out_full = fi;
    Q_out_full = fq;
    #1;
    o_rd = in_rd_en; o_wi = I_out_wr_en; o_wq = Q_out_wr_en;
    o_i  = I_dout;   o_q  = Q_dout;      o_e  = in_empty;
    if (o_rd && bq.size() != 0) void'(bq.pop_front());
    @(posedge clock);
    #1;
    in_empty = 1'b1; I_out_full = 1'b1; Q_out_full = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    bq.delete(); exp_i.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_empty = 1'b0; din = 8'hAA;
    I_out_full = 1'b0; Q_out_full = 1'b0;
    @(posedge clock); @(posedge clock);
    @(negedge clock); #1;
    checks++; if (in_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en actual=%b required=0", in_rd_en); end
    checks++; if (I_out_wr_en !== 1'b0 || Q_out_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en actual=%b%b required=00", I_out_wr_en, Q_out_wr_en); end
    checks++; if (I_dout !== 32'd0 || Q_dout !== 32'd0) begin errors++; $display("FAIL reset_dout actual=%h/%h required=0/0", I_dout, Q_dout); end
    checks++; if (sample_count !== 32'd0) begin errors++; $display("FAIL reset_count actual=%0d required=0", sample_count); end
    @(posedge clock); #1;
    reset = 1'b0; in_empty = 1'b1; I_out_full = 1'b1; Q_out_full = 1'b1;
  endtask

  task automatic test_basic();
    int n_w = 0, cyc_w = 0;
    logic [31:0] ri, rq;
`ifdef IQ_QUANTIZE_EN
    ri = 32'h0048D000; rq = 32'hFFFFF800;
`else
    ri = 32'h00001234; rq = 32'hFFFFFFFE;
`endif
    push_sample(8'h34, 8'h12, 8'hFE, 8'hFF);
    for (int c = 1; c <= 10; c++) begin
      step(1'b0, 1'b0, 1'b0);
      if (o_wi) begin
        n_w++;
        if (cyc_w == 0) cyc_w = c;
        checks++; if (o_i !== ri || o_q !== rq) begin errors++; $display("FAIL basic_data actual=%h/%h required=%h/%h", o_i, o_q, ri, rq); end
      end
    end
    checks++; if (n_w != 1) begin errors++; $display("FAIL basic_writes actual=%0d required=1", n_w); end
    checks++; if (cyc_w != 5) begin errors++; $display("FAIL basic_latency actual=%0d required=5", cyc_w); end
    checks++; if (sample_count !== 32'd1) begin errors++; $display("FAIL basic_count actual=%0d required=1", sample_count); end
    exp_i.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    int n_w = 0;
    push_sample(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    push_sample(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'($urandom), 1'b1);
      checks++; if (o_rd !== 1'b0 || o_wi !== 1'b0 || o_wq !== 1'b0) begin errors++; $display("FAIL bp_stall c=%0d actual rd=%b wr=%b%b required 0/00", c, o_rd, o_wi, o_wq); end
      checks++; if (o_i !== exp_i[0] || o_q !== exp_q[0]) begin errors++; $display("FAIL bp_hold c=%0d actual=%h/%h required=%h/%h", c, o_i, o_q, exp_i[0], exp_q[0]); end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (o_wi !== 1'b1 || o_wq !== 1'b1 || o_rd !== 1'b0) begin errors++; $display("FAIL bp_release actual wr=%b%b rd=%b required 11/0", o_wi, o_wq, o_rd); end
    checks++; if (o_i !== exp_i[0] || o_q !== exp_q[0]) begin errors++; $display("FAIL bp_data actual=%h/%h required=%h/%h", o_i, o_q, exp_i[0], exp_q[0]); end
    void'(exp_i.pop_front()); void'(exp_q.pop_front());
    for (int c = 0; c < 20 && exp_i.size() != 0; c++) begin
      step(1'b0, 1'b0, 1'b0);
      if (o_wi) begin
        n_w++;
        checks++; if (o_i !== exp_i[0] || o_q !== exp_q[0]) begin errors++; $display("FAIL bp_next actual=%h/%h required=%h/%h", o_i, o_q, exp_i[0], exp_q[0]); end
        void'(exp_i.pop_front()); void'(exp_q.pop_front());
      end
    end
    checks++; if (n_w != 1) begin errors++; $display("FAIL bp_next_writes actual=%0d required=1", n_w); end
    checks++; if (sample_count !== 32'd3) begin errors++; $display("FAIL bp_count actual=%0d required=3", sample_count); end
  endtask

  task automatic test_empty_toggle();
    int n_w = 0, bad_rd = 0;
    for (int s = 0; s < 3; s++)
      push_sample(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int c = 0; c < 60 && exp_i.size() != 0; c++) begin
      step(1'(c % 2), 1'b0, 1'b0);
      if (o_rd && o_e) bad_rd++;
      if (o_wi) begin
        n_w++;
        checks++; if (o_i !== exp_i[0] || o_q !== exp_q[0]) begin errors++; $display("FAIL toggle_data n=%0d actual=%h/%h required=%h/%h", n_w, o_i, o_q, exp_i[0], exp_q[0]); end
        void'(exp_i.pop_front()); void'(exp_q.pop_front());
      end
    end
    checks++; if (n_w != 3) begin errors++; $display("FAIL toggle_writes actual=%0d required=3", n_w); end
    checks++; if (bad_rd != 0) begin errors++; $display("FAIL toggle_rd_when_empty actual=%0d required=0", bad_rd); end
    checks++; if (sample_count !== 32'd6) begin errors++; $display("FAIL toggle_count actual=%0d required=6", sample_count); end
  endtask

  task automatic test_reset_mid();
    int n_w = 0;
    logic [31:0] ri, rq;
`ifdef IQ_QUANTIZE_EN
    ri = 32'd1024; rq = 32'd2048;
`else
    ri = 32'd1;    rq = 32'd2;
`endif
    bq.push_back(8'($urandom)); bq.push_back(8'($urandom));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    do_reset();
    push_sample(8'h01, 8'h00, 8'h02, 8'h00);
    for (int c = 0; c < 10 && n_w == 0; c++) begin
      step(1'b0, 1'b0, 1'b0);
      if (o_wi) begin
        n_w++;
        checks++; if (o_i !== ri || o_q !== rq) begin errors++; $display("FAIL rmid_data actual=%h/%h required=%h/%h", o_i, o_q, ri, rq); end
      end
    end
    checks++; if (n_w != 1) begin errors++; $display("FAIL rmid_writes actual=%0d required=1", n_w); end
    checks++; if (sample_count !== 32'd1) begin errors++; $display("FAIL rmid_count actual=%0d required=1", sample_count); end
  endtask

  task automatic test_stream();
    int n_w = 0, bad_pair = 0, bad_rd = 0;
    do_reset();
    for (int s = 0; s < 1000; s++)
      push_sample(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int c = 0; c < 20000 && exp_i.size() != 0; c++) begin
      step(1'($urandom_range(3) == 0), 1'($urandom_range(4) == 0), 1'($urandom_range(4) == 0));
      if (o_wi !== o_wq) bad_pair++;
      if ((o_rd && o_e) || (o_rd && o_wi)) bad_rd++;
      if (o_wi) begin
        n_w++;
        checks++; if (o_i !== exp_i[0] || o_q !== exp_q[0]) begin errors++; $display("FAIL stream_data n=%0d actual=%h/%h required=%h/%h", n_w, o_i, o_q, exp_i[0], exp_q[0]); end
        void'(exp_i.pop_front()); void'(exp_q.pop_front());
      end
    end
    checks++; if (n_w != 1000) begin errors++; $display("FAIL stream_writes actual=%0d required=1000", n_w); end
    checks++; if (bad_pair != 0) begin errors++; $display("FAIL stream_wr_pair actual=%0d required=0", bad_pair); end
    checks++; if (bad_rd != 0) begin errors++; $display("FAIL stream_rd_rules actual=%0d required=0", bad_rd); end
    checks++; if (sample_count !== 32'd1000) begin errors++; $display("FAIL stream_count actual=%0d required=1000", sample_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_toggle();
    test_reset_mid();
    test_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iq_deinterleave.md
# iq_deinterleave

Front-end stage that converts the raw interleaved byte stream from the RF capture FIFO into separate signed I and Q sample streams for the channel filter's input FIFOs. It reads four bytes per complex sample (I low, I high, Q low, Q high) and reassembles two 16-bit signed values. It optionally quantizes them to the pipeline's fixed-point format and writes I and Q into their FIFOs in the same cycle. It is the writer of the I/Q FIFO pair that the complex FIR reads.

## Interface
- DATA_WIDTH, 32, width of I_dout/Q_dout; must be ≥ 16 + BITS.
- BITS, 10, fixed-point fractional bits applied when quantization is compiled in.

- clock  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- in_rd_en  output  1  pops one byte from the capture FIFO.
- in_empty  input  1  capture FIFO empty.
- din  input  8  capture FIFO head byte (first-word-fall-through: valid whenever in_empty=0).
- I_out_wr_en  output  1  push I_dout into the I FIFO.
- Q_out_wr_en  output  1  push Q_dout into the Q FIFO; always equal to I_out_wr_en.
- I_out_full  input  1  I FIFO full.
- Q_out_full  input  1  Q FIFO full.
- I_dout  output  DATA_WIDTH  signed I sample.
- Q_dout  output  DATA_WIDTH  signed Q sample.
- sample_count  output  32  number of complex samples written since reset; wraps at 2^32.

## Operation
- FSM states: S_ILO, S_IHI, S_QLO, S_QHI, S_WRITE. The reset state is S_ILO.
- Byte states:
  - in_rd_en = !in_empty.
  - When in_rd_en=1, din is captured into that state's byte register and the FSM advances.
  - When in_empty=1, the FSM holds and no byte is captured.
  - Sequence is S_ILO→S_IHI→S_QLO→S_QHI→S_WRITE.
- S_WRITE:
  - in_rd_en = 0.
  - I_out_wr_en = Q_out_wr_en = !I_out_full && !Q_out_full.
  - When the write fires, sample_count increments and the FSM returns to S_ILO. Otherwise it holds.
  - I and Q are never written separately. If either FIFO is full, neither is written.
- Sample assembly: I16 = {IHI, ILO}, Q16 = {QHI, QLO}, both interpreted as signed two's complement.
- I_dout/Q_dout are registered. They are loaded on the S_QHI→S_WRITE transition and held stable throughout S_WRITE.
- I_dout/Q_dout are sign-extended to DATA_WIDTH, then processed as set out under Configuration.
- Outside S_WRITE, I_dout/Q_dout keep their last loaded value. Consumers qualify them only with the write enables.

## Timing
- Reset values:
  - state = S_ILO.
  - I_dout = Q_dout = 0.
  - sample_count = 0.
  - Byte registers = 0.
  - in_rd_en = I_out_wr_en = Q_out_wr_en = 0 during the reset cycle.
- Reset mid-sample: any partially collected bytes are discarded. After reset, the next byte read is treated as I low.
- Read and write enables are combinational from the state and the FIFO flags.
- At most one byte is read per cycle. No read occurs in the same cycle as a write.
- Latency:
  - Best case, the write fires in the cycle after the Q-high byte is read.
  - Minimum of 5 cycles per complex sample: 4 reads + 1 write.
- Back-pressure from a full output FIFO stalls only S_WRITE. No input bytes are read while stalled.
- If a full flag deasserts in the same cycle, the write fires that cycle.
- An empty input FIFO stalls the byte state the FSM is currently in. No partial sample is ever emitted.

## Configuration
- IQ_QUANTIZE_EN defined: I_dout = sext(I16) << BITS and Q_dout = sext(Q16) << BITS, i.e. the fixed-point quantize step.
- IQ_QUANTIZE_EN undefined: I_dout = sext(I16) and Q_dout = sext(Q16). The raw samples pass through and BITS is unused.
- Both options have the same FSM, handshake and latency.

## Test plan
- Quantize on, bytes 0x34,0x12,0xFE,0xFF with no back-pressure → a single write with I_dout=0x0048D000, Q_dout=0xFFFFF800 (−2048), sample_count=1, and the write in the 5th cycle.
- Quantize off, same bytes → I_dout=0x00001234, Q_dout=0xFFFFFFFE.
- Q_out_full=1 for 10 cycles after the 4th byte → no write enables and no in_rd_en while held. The write fires in the first cycle both full flags are 0, and I/Q stay stable throughout.
- in_empty toggled every other cycle over 3 samples (12 bytes) → exactly 3 writes with correctly paired I/Q, and in_rd_en never asserts while in_empty=1.
- reset asserted after 2 bytes of a sample, then bytes 0x01,0x00,0x02,0x00 → first output has I16=1, Q16=2; sample_count=1.
- Continuous stream of 1000 samples with a random full/empty pattern → the output matches the reference sequence, I_out_wr_en ≡ Q_out_wr_en every cycle, and sample_count=1000.
